// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access pipeline stage placed after the execute ALU.
//            Runs a req/ack handshake with data memory for LW/SW/LB/LBU/SB,
//            builds big-endian byte enables and replicated store data, and
//            produces the write-back value with sign/zero extension for byte
//            loads. Any other opcode passes aluResult straight to write-back.
//            Upstream is stalled through busy while a request is outstanding.
// Ports    : clock, reset_n         - clock, async active-low reset
//            enable_mem             - execute result valid
//            insn, aluResult, rtData - instruction, address/result, store data
//            mem_req/we/addr/be/wdata, mem_ack, mem_rdata - memory handshake
//            wbData, wb_valid       - write-back value and its 1-cycle strobe
//            busy                   - stage occupied (state == REQ)
//            misaligned, timeout    - 1-cycle event pulses
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable_mem,
  input  logic [31:0] insn,
  input  logic [31:0] aluResult,
  input  logic [31:0] rtData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wbData,
  output logic        wb_valid,
  output logic        busy,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        timeout_q, timeout_d;
  // Captured load attributes, needed when the ack returns.
  logic        is_load_q, is_load_d;
  logic        is_byte_q, is_byte_d;
  logic        is_signed_q, is_signed_d;
  logic [1:0]  offset_q, offset_d;

  logic [5:0]  opcode;
  logic        op_lw, op_sw, op_lb, op_lbu, op_sb;
  logic        op_mem, op_word;
  logic [3:0]  byte_be;
  logic [7:0]  rd_byte;
  logic [31:0] load_value;

  logic unused_insn_bits;
  assign unused_insn_bits = &{1'b0, insn[25:0]};

  assign opcode  = insn[31:26];
  assign op_lw   = (opcode == OP_LW);
  assign op_sw   = (opcode == OP_SW);
  assign op_lb   = (opcode == OP_LB);
  assign op_lbu  = (opcode == OP_LBU);
  assign op_sb   = (opcode == OP_SB);
  assign op_word = op_lw | op_sw;
  assign op_mem  = op_word | op_lb | op_lbu | op_sb;
  // Big-endian: offset 0 addresses bits [31:24], i.e. enable bit 3.
  assign byte_be = 4'b1000 >> aluResult[1:0];

  always_comb begin
    rd_byte = 8'h00;
    case (offset_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    if (!is_byte_q)
      load_value = mem_rdata;
    else if (is_signed_q)
      load_value = {{24{rd_byte[7]}}, rd_byte};
    else
      load_value = {24'h000000, rd_byte};
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    wb_data_d    = wb_data_q;
    is_load_d    = is_load_q;
    is_byte_d    = is_byte_q;
    is_signed_d  = is_signed_q;
    offset_d     = offset_q;
    wb_valid_d   = 1'b0;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy is low in IDLE, so enable_mem alone means accept.
        if (enable_mem) begin
          if (!op_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = aluResult;
          end else if (op_word && (aluResult[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            wait_cnt_d  = 8'd0;
            mem_addr_d  = {aluResult[31:2], 2'b00};
            mem_we_d    = op_sw | op_sb;
            mem_be_d    = op_word ? 4'b1111 : byte_be;
            mem_wdata_d = op_sb ? {4{rtData[7:0]}} : rtData;
            is_load_d   = op_lw | op_lb | op_lbu;
            is_byte_d   = op_lb | op_lbu;
            is_signed_d = op_lb;
            offset_d    = aluResult[1:0];
          end
        end
      end
      default: begin
        // Ack is checked first so an ack on the final wait edge wins.
        if (mem_ack) begin
          state_d = ST_IDLE;
          if (is_load_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = load_value;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == MAX_WAIT_C) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      wb_data_q    <= 32'd0;
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      is_load_q    <= 1'b0;
      is_byte_q    <= 1'b0;
      is_signed_q  <= 1'b0;
      offset_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_data_q    <= wb_data_d;
      wb_valid_q   <= wb_valid_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
      is_load_q    <= is_load_d;
      is_byte_q    <= is_byte_d;
      is_signed_q  <= is_signed_d;
      offset_q     <= offset_d;
    end
  end

  assign mem_req    = (state_q == ST_REQ);
  assign busy       = (state_q == ST_REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign wbData     = wb_data_q;
  assign wb_valid   = wb_valid_q;
  assign misaligned = misaligned_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Table of operations
//            with expected memory-side values; write-back values go through
//            a scoreboard queue checked whenever wb_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int MAX_WAIT = 15;
  localparam int K_PASS = 0;
  localparam int K_MEM  = 1;
  localparam int K_MIS  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_mem = 1'b0;
  logic [31:0] insn = 32'd0;
  logic [31:0] aluResult = 32'd0;
  logic [31:0] rtData = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, mem_we, wb_valid, busy, misaligned, timeout;
  logic [31:0] mem_addr, mem_wdata, wbData;
  logic [3:0]  mem_be;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable_mem (enable_mem),
    .insn       (insn),
    .aluResult  (aluResult),
    .rtData     (rtData),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wbData     (wbData),
    .wb_valid   (wb_valid),
    .busy       (busy),
    .misaligned (misaligned),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] insn;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          kind;
    int          delay;   // edges after accept until ack; 0 = never ack
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        has_wb;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every wb_valid pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got wb_valid=1 data %h expected no pulse", wbData);
      end else begin
        chk("wbData", wbData, exp_q.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    enable_mem = 1'b1;
    insn       = v.insn;
    aluResult  = v.alu;
    rtData     = v.rt;
    if (v.has_wb) exp_q.push_back(v.wb);
    @(posedge clock);
    #1 enable_mem = 1'b0;
    @(negedge clock);
    if (v.kind == K_PASS) begin
      chk("pass_mem_req", {31'd0, mem_req}, 32'd0);
      chk("pass_busy", {31'd0, busy}, 32'd0);
    end else if (v.kind == K_MIS) begin
      chk("mis_pulse", {31'd0, misaligned}, 32'd1);
      chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
      chk("mis_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
      chk("mis_mem_req2", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("mem_req", {31'd0, mem_req}, 32'd1);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("mem_addr", mem_addr, v.alu & 32'hFFFF_FFFC);
      chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
      chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
      chk("mem_wdata", mem_wdata, v.wdata);
      if (v.delay > 0) begin
        for (int i = 1; i < v.delay; i++) begin
          @(posedge clock);
          @(negedge clock);
          chk("wait_busy", {31'd0, busy}, 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        @(posedge clock);
        #1 mem_ack = 1'b0;
        mem_rdata = $urandom;
        @(negedge clock);
        chk("ack_busy", {31'd0, busy}, 32'd0);
        chk("ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ack_timeout", {31'd0, timeout}, 32'd0);
      end else begin
        for (int i = 1; i <= MAX_WAIT; i++) begin
          @(posedge clock);
          @(negedge clock);
          if (i < MAX_WAIT) begin
            chk("to_early", {31'd0, timeout}, 32'd0);
            chk("to_busy", {31'd0, busy}, 32'd1);
          end else begin
            chk("to_pulse", {31'd0, timeout}, 32'd1);
            chk("to_busy_end", {31'd0, busy}, 32'd0);
          end
        end
        @(negedge clock);
        chk("to_pulse_end", {31'd0, timeout}, 32'd0);
      end
    end
    @(posedge clock);
    #2 chk("wb_consumed", exp_q.size(), 32'd0);
  endtask

  initial begin
    // ---- vector table ------------------------------------------------------
    //          insn          alu           rt            rdata         kind   dly be      we    wdata         wb?   wb
    vecs[0]  = '{32'h0000_0020, 32'h1234_5678, 32'h0,        32'h0,        K_PASS, 0, 4'b0000, 1'b0, 32'h0,        1'b1, 32'h1234_5678};
    vecs[1]  = '{32'h8C00_0000, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, K_MEM, 3, 4'b1111, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0203, 32'h0,        32'h0000_00F0, K_MEM, 2, 4'b0001, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF0};
    vecs[3]  = '{32'h9000_0000, 32'h0000_0203, 32'h0,        32'h0000_00F0, K_MEM, 1, 4'b0001, 1'b0, 32'h0,        1'b1, 32'h0000_00F0};
    vecs[4]  = '{32'hA000_0000, 32'h0000_0101, 32'h0000_00AB, 32'h0,        K_MEM, 1, 4'b0100, 1'b1, 32'hABAB_ABAB, 1'b0, 32'h0};
    vecs[5]  = '{32'hAC00_0000, 32'h0000_0102, 32'h5555_5555, 32'h0,        K_MIS, 0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{32'hAC00_0000, 32'h0000_0040, 32'h1122_3344, 32'h0,        K_MEM, 2, 4'b1111, 1'b1, 32'h1122_3344, 1'b0, 32'h0};
    vecs[7]  = '{32'h8000_0000, 32'h0000_0200, 32'h0,        32'h80FF_FFFF, K_MEM, 1, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFF_FF80};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0201, 32'h0,        32'h007F_0000, K_MEM, 1, 4'b0100, 1'b0, 32'h0,        1'b1, 32'h0000_007F};
    vecs[9]  = '{32'h9000_0000, 32'h0000_0302, 32'h0,        32'h0000_AB00, K_MEM, 4, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h0000_00AB};
    vecs[10] = '{32'h8C00_0000, 32'h0000_0101, 32'h0,        32'h0,        K_MIS, 0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{32'h8C00_0000, 32'h0000_0500, 32'h0,        32'h0,        K_MEM, 0, 4'b1111, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{32'h8C00_0000, 32'h0000_0600, 32'h0,        32'hCAFE_F00D, K_MEM, MAX_WAIT, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D};
    vecs[13] = '{32'h3C00_0000, 32'hFFFF_0000, 32'h0,        32'h0,        K_PASS, 0, 4'b0000, 1'b0, 32'h0,        1'b1, 32'hFFFF_0000};

    // ---- reset state -------------------------------------------------------
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wbData", wbData, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_flags", {29'd0, misaligned, timeout, mem_we}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // ---- table -------------------------------------------------------------
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // ---- back-to-back pass-through: one pulse per cycle ----------------------
    @(negedge clock);
    enable_mem = 1'b1;
    insn       = 32'h0000_0020;
    aluResult  = 32'hA000_0001;
    exp_q.push_back(32'hA000_0001);
    @(posedge clock);
    #1 aluResult = 32'hA000_0002;
    exp_q.push_back(32'hA000_0002);
    @(posedge clock);
    #1 aluResult = 32'hA000_0003;
    exp_q.push_back(32'hA000_0003);
    @(posedge clock);
    #1 enable_mem = 1'b0;
    @(negedge clock);
    chk("b2b_last_pulse", {31'd0, wb_valid}, 32'd1);
    @(posedge clock);
    #2 chk("b2b_consumed", exp_q.size(), 32'd0);

    // ---- enable_mem while busy is ignored ------------------------------------
    @(negedge clock);
    enable_mem = 1'b1;
    insn       = 32'h8C00_0000;
    aluResult  = 32'h0000_0100;
    exp_q.push_back(32'h0000_55AA);
    @(posedge clock);
    #1 insn = 32'h0000_0020;
    aluResult = 32'h0000_0999;
    @(negedge clock);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    chk("hold_addr", mem_addr, 32'h0000_0100);
    @(negedge clock);
    enable_mem = 1'b0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'h0000_55AA;
    @(posedge clock);
    #1 mem_ack = 1'b0;
    @(posedge clock);
    #2 chk("hold_consumed", exp_q.size(), 32'd0);
    @(negedge clock);
    chk("hold_wb_quiet", {31'd0, wb_valid}, 32'd0);
    chk("hold_wb_holds", wbData, 32'h0000_55AA);

    // ---- reset mid-REQ -------------------------------------------------------
    @(negedge clock);
    enable_mem = 1'b1;
    insn       = 32'h8C00_0000;
    aluResult  = 32'h0000_0080;
    @(posedge clock);
    #1 enable_mem = 1'b0;
    @(posedge clock);
    #1 chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(posedge clock);
    #1 mem_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_wb", {31'd0, wb_valid}, 32'd0);
    run_vec(vecs[0]);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck bench still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached expected bench completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage that sits directly downstream of the execute ALU. It consumes the ALU result (the effective address for loads and stores, or a plain result otherwise), the instruction word and the rt operand. It runs a req/ack handshake with data memory for LW/SW/LB/LBU/SB and produces the write-back value with byte-lane selection and sign or zero extension. While a memory transaction is outstanding it stalls the upstream stage through `busy`.

## Interface
- `MAX_WAIT`, default 15: cycles to wait in REQ for `mem_ack` before abandoning the access (range 1..255).
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable_mem`  in  1  execute result valid this cycle.
- `insn`  in  32  instruction word; opcode is `insn[31:26]`.
- `aluResult`  in  32  ALU output: effective address or result.
- `rtData`  in  32  store data.
- `mem_req`  out  1  memory request; held until ack or timeout.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{aluResult[31:2],2'b00}`.
- `mem_be`  out  4  byte enables; bit 3 = bits [31:24].
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  memory completes the access this cycle.
- `mem_rdata`  in  32  read word; valid when `mem_ack` is 1.
- `wbData`  out  32  write-back value.
- `wb_valid`  out  1  one-cycle pulse; `wbData` is valid.
- `busy`  out  1  stage cannot accept; upstream must hold.
- `misaligned`  out  1  one-cycle pulse: LW/SW address with [1:0] not 00.
- `timeout`  out  1  one-cycle pulse: access abandoned.

## Operation
- **Accept:** the stage accepts when `enable_mem` is 1 and `busy` is 0 at a rising edge. Inputs are registered at accept; `enable_mem` while `busy` is ignored.
- **Opcode classes:**
  - Memory ops: LW 100011, SW 101011, LB 100000, LBU 100100, SB 101000.
  - Everything else is pass-through: `wbData` = `aluResult`.
- **Byte order:** big-endian; byte offset `o` = `aluResult[1:0]`, and offset 0 = bits [31:24].
- **SW:** `mem_be`=1111, `mem_wdata`=`rtData`.
- **SB:** `mem_be` = 4'b1000 >> o, `mem_wdata` = {4{`rtData[7:0]`}}.
- **LW:** `mem_be`=1111; `wbData` = `mem_rdata`.
- **LB/LBU:** `mem_be` = 4'b1000 >> o. The selected byte is `mem_rdata[31-8o -: 8]`; LB sign-extends it and LBU zero-extends it.
- **Misaligned LW/SW:** no request is issued, `misaligned` pulses, and `wb_valid` stays 0. Byte ops are never misaligned.
- **FSM states:** IDLE, REQ.
  - IDLE → REQ when a memory op is accepted and aligned.
  - REQ → IDLE when `mem_ack` is sampled 1. Loads then pulse `wb_valid`; stores complete silently.
  - REQ → IDLE when the wait counter reaches `MAX_WAIT` without ack. `timeout` pulses and `wb_valid` stays 0.
- **Wait counter:** 8 bits, cleared on entry to REQ, incremented each REQ cycle without ack.
- **Stability:** `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are registered and stay stable for the whole of REQ. `mem_req` is 1 exactly while state = REQ.
- **Outside REQ:** `mem_ack` is ignored.
- **`busy`:** (state == REQ), driven combinationally from the state register.
- **`wbData`:** holds its last value between pulses.

## Timing
- **Reset:** all outputs are 0, state is IDLE and the counter is 0. Reset is asynchronous, both assertion and mid-transaction. When it asserts mid-REQ, `mem_req` drops immediately with no pulse, and a late `mem_ack` after release is ignored.
- **Pass-through:** accept at edge N gives `wb_valid`=1 in cycle N..N+1 (1-cycle latency). Back-to-back accepts then give a `wb_valid` pulse every cycle.
- **Memory op:** accept at edge N raises `mem_req`/`busy` after edge N.
  - Ack sampled at edge N+k (k ≥ 1) drops `mem_req`/`busy` after N+k; for loads, `wb_valid` is 1 for the cycle after N+k.
  - Zero-wait memory (ack at the first REQ edge) makes `busy` last exactly 1 cycle.
- **Next accept:** possible at the edge after `busy` falls.
- **Timeout:** with no ack, `timeout` pulses in the cycle after edge N+MAX_WAIT, and `busy` falls at the same time.
- **Ack on the final wait edge:** if ack arrives on the edge where the counter would reach `MAX_WAIT`, the ack wins and `timeout` does not pulse.
- **Misaligned:** accept at edge N pulses `misaligned` after N; `busy` never rises.

## Test plan
- **Pass-through:** ADD insn with aluResult=0x12345678 → `wb_valid` pulse next cycle with `wbData`=0x12345678; no `mem_req`.
- **LW:** addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF → `mem_be`=1111, `busy` high 3 cycles, then `wb_valid` with 0xDEADBEEF.
- **LB/LBU:** addr 0x203, rdata 0x000000F0.
  - LB → `mem_be`=0001, `wbData`=0xFFFFFFF0.
  - LBU → `wbData`=0x000000F0.
- **SB:** addr 0x101, rtData=0xAB → `mem_addr`=0x100, `mem_be`=0100, `mem_wdata`=0xABABABAB, `mem_we`=1; no `wb_valid` after ack.
- **Misaligned SW and timeout:**
  - SW to 0x102 → `misaligned` pulse, `mem_req` never 1.
  - LW with no ack, MAX_WAIT=15 → `timeout` pulse 15 cycles after accept, then `busy`=0.
- **Reset mid-REQ:** `reset_n` low during REQ → `mem_req`, `busy` and `wb_valid` go to 0 at once; after release, an ack is ignored and a new accept works.
